// File: rtl/pc_seq_pkg.sv
// Shared definitions for the next-PC sequencer.
//   state_t      : sequencer FSM states (boot, run, flush, stall, halt)
//   PC_W_DEFAULT : default program counter / offset width
//   HOLD_OFF     : relative offset that freezes the PC (count + 0)
package pc_seq_pkg;

  localparam int PC_W_DEFAULT = 10;
  localparam int HOLD_OFF     = 0;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_STALL = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

endpackage

// File: rtl/pc_seq_ctrl_stall_timer.sv
// Consecutive memory-busy cycle counter.
//   clk, rst : clock, synchronous active-high reset
//   clear    : return the count to zero (memory no longer busy)
//   start    : first busy cycle; count loads 1
//   step     : another busy cycle; count increments (saturating)
//   tc       : the next step brings the count to STALL_MAX
module stall_timer #(
  parameter int STALL_MAX = 255,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic start,
  input  logic step,
  output logic tc
);

  localparam logic [CNT_W:0] LIMIT   = (CNT_W+1)'(STALL_MAX);
  localparam logic [CNT_W:0] ONE_EXT = (CNT_W+1)'(1);

  logic [CNT_W-1:0] value;
  logic [CNT_W:0]   value_inc;

  // One bit wider than the counter so the compare cannot wrap.
  assign value_inc = {1'b0, value} + ONE_EXT;
  assign tc        = (value_inc >= LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= '0;
    end else if (start) begin
      value <= CNT_W'(1);
    end else if (step && (value != '1)) begin
      value <= value_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer for the 2-stage fetch/execute core.
// Inputs : clk, rst (sync, active high), count (fetch PC), ex_valid and the
//          decoded control flow of the execute instruction (is_branch,
//          is_jal, is_jr, is_halt, br_cond, br_off), mem_busy.
// Outputs: sel_m1/sel_m2/pc_off steer the PC muxes; kill squashes the
//          execute instruction; stall holds the pipeline register;
//          link_we/link_pc write the return address; halted and the sticky
//          err_timeout report core status; fsm_state exposes the FSM.
// Handshake: there is no valid/ready pair here; mem_busy is a level that
// freezes the core for every cycle it is high, and the instruction in
// execute is re-evaluated on the first cycle it is low.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int PC_W      = PC_W_DEFAULT,
  parameter int STALL_MAX = 255,
  parameter int CNT_W     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] count,
  input  logic            ex_valid,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jr,
  input  logic            is_halt,
  input  logic            br_cond,
  input  logic [PC_W-1:0] br_off,
  input  logic            mem_busy,
  output logic            sel_m1,
  output logic            sel_m2,
  output logic [PC_W-1:0] pc_off,
  output logic            kill,
  output logic            stall,
  output logic            link_we,
  output logic [PC_W-1:0] link_pc,
  output logic            halted,
  output logic            err_timeout,
  output state_t          fsm_state
);

  // A single busy cycle already reaches the limit when STALL_MAX <= 1.
  localparam bit START_LAST = (STALL_MAX <= 1);

  state_t state, state_n, eff_st;
  logic   flush_owed, owed_n;
  logic   eff;
  logic   t_start, t_step, t_tc;
  logic   timeout;

  assign eff       = ex_valid & ~kill;
  assign link_pc   = count;
  assign fsm_state = state;

  stall_timer #(
    .STALL_MAX (STALL_MAX),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (~mem_busy),
    .start (t_start),
    .step  (t_step),
    .tc    (t_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BOOT;
      flush_owed  <= 1'b0;
      kill        <= 1'b1;
      halted      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      flush_owed  <= owed_n;
      // A stall entered from FLUSH keeps the wrong-path slot squashed.
      kill        <= (state_n == ST_BOOT) || (state_n == ST_FLUSH) ||
                     (state_n == ST_HALT) || ((state_n == ST_STALL) && owed_n);
      halted      <= (state_n == ST_HALT);
      err_timeout <= err_timeout | timeout;
    end
  end

  always_comb begin
    state_n = state;
    owed_n  = flush_owed;
    sel_m1  = 1'b0;
    sel_m2  = 1'b0;
    pc_off  = PC_W'(HOLD_OFF);
    stall   = 1'b0;
    link_we = 1'b0;
    t_start = 1'b0;
    t_step  = 1'b0;
    timeout = 1'b0;

    // Once memory is ready again, the stall cycle acts as the state it
    // interrupted, so the held instruction resolves with no extra bubble.
    eff_st = state;
    if ((state == ST_STALL) && !mem_busy) begin
      eff_st = flush_owed ? ST_FLUSH : ST_RUN;
    end

    case (eff_st)
      ST_BOOT: begin
        state_n = ST_RUN;
      end

      ST_RUN, ST_FLUSH: begin
        if (mem_busy) begin
          sel_m1  = 1'b1;
          stall   = 1'b1;
          t_start = 1'b1;
          owed_n  = (eff_st == ST_FLUSH);
          if (START_LAST) begin
            state_n = ST_HALT;
            timeout = 1'b1;
          end else begin
            state_n = ST_STALL;
          end
        end else if (eff_st == ST_FLUSH) begin
          state_n = ST_RUN;
        end else if (eff && is_halt) begin
          sel_m1  = 1'b1;
          state_n = ST_HALT;
        end else if (eff && is_jr) begin
          sel_m2  = 1'b1;
          state_n = ST_FLUSH;
        end else if (eff && is_jal) begin
          sel_m1  = 1'b1;
          pc_off  = br_off;
          link_we = 1'b1;
          state_n = ST_FLUSH;
        end else if (eff && is_branch && br_cond) begin
          sel_m1  = 1'b1;
          pc_off  = br_off;
          state_n = ST_FLUSH;
        end else begin
          state_n = ST_RUN;
        end
      end

      ST_STALL: begin
        sel_m1 = 1'b1;
        stall  = 1'b1;
        t_step = 1'b1;
        if (t_tc) begin
          state_n = ST_HALT;
          timeout = 1'b1;
        end
      end

      ST_HALT: begin
        sel_m1 = 1'b1;
      end

      default: begin
        state_n = ST_BOOT;
      end
    endcase
  end

endmodule
